caliptra_prim_share_unmask: RTL and testbench
=============================================

Name: caliptra_prim_share_unmask

Overview:
- Receiving end of the two-share masking scheme: accepts data words split into two Boolean shares (share0 ^ share1 = data) over a valid/ready handshake and recombines them into plaintext.
- Recombination is glitch-safe. Each share is registered separately, and the XOR takes flop outputs only.
- The result is held in an output register behind a second valid/ready handshake.
- Sits between masked-datapath producers (key vault sideload, masked crypto cores) and unmasked consumers.

Parameters:
- Width, 32, data/share width in bits (1..256).
- CntWidth, 16, width of the delivered-word counter.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous flush/zeroize
- in_valid_i  input  1  share pair valid
- in_ready_o  output  1  share pair accepted when in_valid_i & in_ready_o
- share0_i  input  Width  share 0
- share1_i  input  Width  share 1
- out_valid_o  output  1  unmasked word valid
- out_ready_i  input  1  downstream ready
- data_o  output  Width  unmasked word (share0 ^ share1)
- busy_o  output  1  any stage holds data
- word_cnt_o  output  CntWidth  saturating count of delivered words

Behaviour:
- Interface: one clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset values:
  - Stage valids s1_v and s2_v are 0.
  - All share and data registers are 0.
  - Outputs: in_ready_o=1, out_valid_o=0, data_o=0, busy_o=0, word_cnt_o=0.
- Stage 1 (S1):
  - Registers r_sh0 and r_sh1 capture share0_i and share1_i on an input handshake.
  - Each share gets its own flop; no combinational logic between the input pins and these flops.
- Stage 2 (S2): register r_data captures r_sh0 ^ r_sh1 when S1 advances.
- data_o = r_data.
- Advance rules:
  - s2_adv = s1_v & (!s2_v | out_ready_i).
  - in_ready_o = !clear_i & (!s1_v | s2_adv).
- Latency: 2 cycles from input handshake to out_valid_o. Sustained throughput is 1 word/cycle while out_ready_i=1.
- Backpressure: with out_ready_i=0, two words are buffered (S1+S2), then in_ready_o=0.
- out_valid_o=s2_v. Once asserted, data_o stays stable until the handshake completes (AXI-style; no retraction).
- word_cnt_o:
  - Increments on each output handshake.
  - Saturates at all-ones; no wrap.
- busy_o = s1_v | s2_v.
- clear_i (priority over every handshake in the same cycle):
  - Next cycle: s1_v=s2_v=0; r_sh0, r_sh1 and r_data are 0; word_cnt_o=0.
  - Any input or output handshake coinciding with clear_i is discarded and not counted.
  - in_ready_o=0 while clear_i=1.
- Simultaneous events: input handshake + output handshake in the same cycle with both stages full → S2 takes S1, S1 takes new input, count+1.
- Reset mid-operation: all in-flight words are lost; state returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: CALIPTRA_PRIM_UNMASK_SCRUB_EN
- Defined:
  - When a stage empties without being refilled in the same cycle, its data registers load 0.
  - So data_o=0 and r_sh0/r_sh1=0 whenever the corresponding valid is 0. No share or plaintext residue persists.
- Undefined:
  - Data registers update only on capture; stale values remain when valid=0.
  - Only clear_i and reset zeroize.

Decomposition:
- Package caliptra_prim_unmask_pkg:
  - share_pair_t struct {share0, share1} parameterized via Width (default 32).
  - Constant UnmaskLatency=2.
  - Default CntWidth=16.
- Sub-module caliptra_prim_unmask_stage:
  - One valid/ready register stage with a clear input and a scrub option.
  - Instantiated twice: as S1 (2×Width) and as S2 (Width).

Test Plan:
- Reset → in_ready_o=1, out_valid_o=0, data_o=0, word_cnt_o=0.
- Single word (share0=0xA5A5_0F0F, share1=0xFFFF_0000), out_ready_i=1 → out_valid_o=1 exactly 2 cycles after the handshake, data_o=0x5A5A_0F0F, word_cnt_o=1.
- Streaming 8 random share pairs with out_ready_i=1 → 8 outputs on consecutive cycles, each equal to the XOR of its pair, word_cnt_o=8.
- Backpressure: out_ready_i=0, push 3 words → first 2 accepted, in_ready_o=0 on the third. data_o is stable until out_ready_i=1, then the words drain in order.
- clear_i asserted with both stages full and out_ready_i=1 in the same cycle → no output handshake counted, next cycle busy_o=0, word_cnt_o=0, data_o=0.
- Counter saturation, CntWidth=4: deliver 20 words → word_cnt_o=0xF. With SCRUB_EN, after the final drain data_o=0 while out_valid_o=0.

Source files
------------

// File: rtl/caliptra_prim_unmask_pkg.sv
// Shared types and constants for the two-share unmasking block.
//
// Contents:
//   share_pair_t    - packed pair of Boolean shares at the default width
//   DefaultWidth    - default data/share width
//   DefaultCntWidth - default width of the delivered-word counter
//   UnmaskLatency   - cycles from input handshake to out_valid_o
package caliptra_prim_unmask_pkg;

    localparam int unsigned DefaultWidth    = 32;
    localparam int unsigned DefaultCntWidth = 16;
    localparam int unsigned UnmaskLatency   = 2;

    typedef struct packed {
        logic [DefaultWidth-1:0] share0;
        logic [DefaultWidth-1:0] share1;
    } share_pair_t;

endpackage

// File: rtl/caliptra_prim_unmask_stage.sv
// One valid/ready register stage with synchronous clear and optional scrub.
//
// Ports:
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   clear_i                 - flush: drops the held word and zeroes the data register
//   in_valid_i / in_ready_o - upstream handshake; in_ready_o is low during clear_i
//   data_i                  - word captured on an upstream handshake
//   out_valid_o/out_ready_i - downstream handshake
//   data_o                  - registered word (flop output only)
//
// Scrub = 1 zeroes the data register when the stage empties without a refill.
module caliptra_prim_unmask_stage #(
    parameter int unsigned Width = 32,
    parameter bit          Scrub = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign in_ready_o  = ~clear_i & (~valid_q | out_ready_i);
    assign out_valid_o = valid_q;
    assign data_o      = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            if (Scrub) begin
                data_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/caliptra_prim_share_unmask.sv
// Two-share unmasking stage: registers each share separately, then XORs the
// registered shares into a held output word.
//
// Ports:
//   clk_i, rst_ni             - clock, asynchronous active-low reset
//   clear_i                   - synchronous flush/zeroize, wins over any handshake
//   in_valid_i / in_ready_o   - share pair handshake
//   share0_i, share1_i        - Boolean shares (share0 ^ share1 = data)
//   out_valid_o / out_ready_i - unmasked word handshake
//   data_o                    - unmasked word
//   busy_o                    - any stage holds a word
//   word_cnt_o                - saturating count of delivered words
//
// Build option: CALIPTRA_PRIM_UNMASK_SCRUB_EN zeroes share/data registers
// whenever their stage empties without a refill.
module caliptra_prim_share_unmask
    import caliptra_prim_unmask_pkg::*;
#(
    parameter int unsigned Width    = DefaultWidth,
    parameter int unsigned CntWidth = DefaultCntWidth
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [Width-1:0]    share0_i,
    input  logic [Width-1:0]    share1_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [Width-1:0]    data_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] word_cnt_o
);

`ifdef CALIPTRA_PRIM_UNMASK_SCRUB_EN
    localparam bit ScrubEn = 1'b1;
`else
    localparam bit ScrubEn = 1'b0;
`endif

    typedef struct packed {
        logic [Width-1:0] share0;
        logic [Width-1:0] share1;
    } pair_t;

    pair_t            s1_in, s1_q;
    logic             s1_v, s2_v;
    logic             s2_in_ready;
    logic [Width-1:0] unmasked;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    assign s1_in = '{share0: share0_i, share1: share1_i};

    // S1: shares go straight from pins into their own flops.
    caliptra_prim_unmask_stage #(
        .Width (2 * Width),
        .Scrub (ScrubEn)
    ) u_stage_s1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .data_i      (s1_in),
        .out_valid_o (s1_v),
        .out_ready_i (s2_in_ready),
        .data_o      (s1_q)
    );

    // The shares only meet here, and only as flop outputs, so no glitch can
    // combine a fresh share with a stale one.
    assign unmasked = s1_q.share0 ^ s1_q.share1;

    caliptra_prim_unmask_stage #(
        .Width (Width),
        .Scrub (ScrubEn)
    ) u_stage_s2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (s1_v),
        .in_ready_o  (s2_in_ready),
        .data_i      (unmasked),
        .out_valid_o (s2_v),
        .out_ready_i (out_ready_i),
        .data_o      (data_o)
    );

    assign out_valid_o = s2_v;
    assign busy_o      = s1_v | s2_v;
    assign word_cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (s2_v && out_ready_i && (cnt_q != {CntWidth{1'b1}})) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_caliptra_prim_share_unmask.sv
module tb_caliptra_prim_share_unmask;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sh0 = '0;
    logic [W-1:0]  sh1 = '0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    caliptra_prim_share_unmask #(
        .Width    (W),
        .CntWidth (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .share0_i    (sh0),
        .share1_i    (sh1),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data),
        .busy_o      (busy),
        .word_cnt_o  (cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard model: stage occupancy plus a queue of expected plaintexts.
    logic          m_s1 = 1'b0;
    logic          m_s2 = 1'b0;
    logic [CW-1:0] m_cnt = '0;
    logic [W-1:0]  sb[$];

    always @(negedge clk) begin
        logic adv, rdy, hs_in, hs_out;
        if (!rst_n) begin
            m_s1  <= 1'b0;
            m_s2  <= 1'b0;
            m_cnt <= '0;
            sb.delete();
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_cnt", 64'(cnt), 64'(0));
        end else begin
            adv    = m_s1 & (~m_s2 | out_ready);
            rdy    = ~clear & (~m_s1 | adv);
            hs_in  = in_valid & rdy;
            hs_out = m_s2 & out_ready & ~clear;
            check("in_ready", 64'(in_ready), 64'(rdy));
            check("out_valid", 64'(out_valid), 64'(m_s2));
            check("busy", 64'(busy), 64'(m_s1 | m_s2));
            check("word_cnt", 64'(cnt), 64'(m_cnt));
            if (m_s2 && sb.size() > 0) begin
                check("data", 64'(data), 64'(sb[0]));
            end
`ifdef CALIPTRA_PRIM_UNMASK_SCRUB_EN
            if (!m_s2) check("scrub_data", 64'(data), 64'(0));
`endif
            if (clear) begin
                m_s1  <= 1'b0;
                m_s2  <= 1'b0;
                m_cnt <= '0;
                sb.delete();
            end else begin
                if (hs_out) begin
                    void'(sb.pop_front());
                    if (m_cnt != {CW{1'b1}}) m_cnt <= m_cnt + CW'(1);
                end
                if (hs_in) sb.push_back(sh0 ^ sh1);
                m_s2 <= adv | (m_s2 & ~out_ready);
                m_s1 <= hs_in | (m_s1 & ~adv);
            end
        end
    end

    // Samples the input handshake mid-cycle, then moves just past the next edge.
    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        sh0      = a;
        sh1      = b;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        if (!acc) check("push_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [W-1:0] w0, w1, w2;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_data", 64'(data), 64'(0));
        check("reset_cnt", 64'(cnt), 64'(0));
        rst_n = 1'b1;
        idle(1);

        // Single word, 2-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sh0       = 32'hA5A5_0F0F;
        sh1       = 32'hFFFF_0000;
        step(acc);
        in_valid = 1'b0;
        check("single_accepted", 64'(acc), 64'(1));
        check("single_lat1_valid", 64'(out_valid), 64'(0));
        idle(1);
        check("single_lat2_valid", 64'(out_valid), 64'(1));
        check("single_data", 64'(data), 64'(32'h5A5A_0F0F));
        idle(1);
        check("single_cnt", 64'(cnt), 64'(1));

        // Streaming 8 random pairs from a zeroed counter
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        for (int i = 0; i < 8; i++) push($urandom, $urandom);
        idle(3);
        check("stream_cnt", 64'(cnt), 64'(8));

        // Backpressure: two words buffered, third refused
        out_ready = 1'b0;
        w0 = $urandom; w1 = $urandom; w2 = $urandom;
        push(w0, 32'h1234_5678);
        push(w1, 32'h0F0F_F0F0);
        in_valid = 1'b1;
        sh0      = w2;
        sh1      = 32'hDEAD_BEEF;
        step(acc);
        check("bp_third_refused", 64'(acc), 64'(0));
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_valid", 64'(out_valid), 64'(1));
            check("bp_hold_data", 64'(data), 64'(w0 ^ 32'h1234_5678));
            step(acc);
        end
        out_ready = 1'b1;
        push(w2, 32'hDEAD_BEEF);
        idle(4);
        check("bp_cnt", 64'(cnt), 64'(11));

        // Clear with both stages full and a coincident output handshake
        out_ready = 1'b0;
        push($urandom, $urandom);
        push($urandom, $urandom);
        check("pre_clear_busy", 64'(busy), 64'(1));
        clear     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        #1;
        check("clear_in_ready", 64'(in_ready), 64'(0));
        step(acc);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("clear_busy", 64'(busy), 64'(0));
        check("clear_cnt", 64'(cnt), 64'(0));
        check("clear_data", 64'(data), 64'(0));
        check("clear_out_valid", 64'(out_valid), 64'(0));

        // Counter saturation
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push($urandom, $urandom);
        idle(3);
        check("sat_cnt", 64'(cnt), 64'({CW{1'b1}}));
        check("sat_out_valid", 64'(out_valid), 64'(0));
`ifdef CALIPTRA_PRIM_UNMASK_SCRUB_EN
        check("sat_scrub_data", 64'(data), 64'(0));
`endif

        // Reset mid-operation
        out_ready = 1'b0;
        push($urandom, $urandom);
        push($urandom, $urandom);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_cnt", 64'(cnt), 64'(0));
        check("midrst_data", 64'(data), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'h0000_FFFF, 32'hFFFF_FFFF);
        idle(3);
        check("post_rst_cnt", 64'(cnt), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
